// File: rtl/pong_pkg.sv
// Shared constants for the pong datapath blocks.
// Match FSM encoding, serve directions and field geometry.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_GOAL_HOLD = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int FIELD_W = 640;
  localparam int FIELD_H = 480;

  function automatic logic [3:0] inc4(input logic [3:0] v);
    return v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_frame_delay_ctr.sv
// 8-bit loadable frame down-counter with zero flag.
// Shared by the serve and goal-hold delays of the match FSM.
module frame_delay_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_count,
  output logic       o_zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == 8'd0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong round/match sequencer: serve, play, goal hold, game over.
// Optional ball speed-up on paddle hits with PONG_SPEEDUP_EN.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 7,
  parameter int SERVE_FRAMES   = 60,
  parameter int GOAL_FRAMES    = 30,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       goal_l,
  input  logic       goal_r,
  input  logic       paddle_hit,
  output logic       ball_step,
  output logic       ball_recentre,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state_o,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] speed_lvl
);

  localparam logic [3:0] LP_WIN   = WIN_SCORE[3:0];
  localparam logic [7:0] LP_SERVE = SERVE_FRAMES[7:0];
  localparam logic [7:0] LP_GOAL  = GOAL_FRAMES[7:0];

  state_t     r_state;
  state_t     w_next;
  logic       r_ball_step;
  logic       r_recentre;
  logic       r_serve_dir;
  logic [3:0] r_score_l;
  logic [3:0] r_score_r;
  logic       r_game_over;
  logic       r_winner;
  logic       r_start_d;

  logic       w_step;
  logic       w_serve_dir;
  logic [3:0] w_score_l;
  logic [3:0] w_score_r;
  logic       w_winner;
  logic       w_enter_serve;
  logic       w_recentre;
  logic       w_start_rise;

  logic       w_ctr_en;
  logic       w_ctr_load;
  logic [7:0] w_ctr_val;
  logic [7:0] w_ctr_count;
  logic       w_ctr_zero;

  frame_delay_ctr u_delay (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_ctr_en),
    .i_load     (w_ctr_load),
    .i_load_val (w_ctr_val),
    .o_count    (w_ctr_count),
    .o_zero     (w_ctr_zero)
  );

  assign w_start_rise = start & ~r_start_d;

  always_comb begin
    w_next        = r_state;
    w_step        = 1'b0;
    w_serve_dir   = r_serve_dir;
    w_score_l     = r_score_l;
    w_score_r     = r_score_r;
    w_winner      = r_winner;
    w_enter_serve = 1'b0;
    w_ctr_en      = 1'b0;
    w_ctr_load    = 1'b0;
    w_ctr_val     = LP_SERVE;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_score_l     = 4'd0;
          w_score_r     = 4'd0;
          w_serve_dir   = DIR_LEFT;
          w_ctr_load    = 1'b1;
          w_enter_serve = 1'b1;
          w_next        = ST_SERVE;
        end
      end
      ST_SERVE: begin
        w_ctr_en = frame_tick & ~pause;
        if (w_ctr_en && (w_ctr_count == 8'd1)) begin
          w_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // goal_l wins a simultaneous double goal; a goal also swallows the tick
        if (goal_l) begin
          w_score_r   = inc4(r_score_r);
          w_serve_dir = DIR_LEFT;
          w_ctr_load  = 1'b1;
          w_ctr_val   = LP_GOAL;
          w_next      = ST_GOAL_HOLD;
        end else if (goal_r) begin
          w_score_l   = inc4(r_score_l);
          w_serve_dir = DIR_RIGHT;
          w_ctr_load  = 1'b1;
          w_ctr_val   = LP_GOAL;
          w_next      = ST_GOAL_HOLD;
        end else if (frame_tick && !pause) begin
          w_step = 1'b1;
        end
      end
      ST_GOAL_HOLD: begin
        w_ctr_en = frame_tick;
        if (w_ctr_zero) begin
          if ((r_score_l == LP_WIN) || (r_score_r == LP_WIN)) begin
            w_winner = (r_score_r == LP_WIN);
            w_next   = ST_GAME_OVER;
          end else begin
            w_ctr_load    = 1'b1;
            w_enter_serve = 1'b1;
            w_next        = ST_SERVE;
          end
        end
      end
      ST_GAME_OVER: begin
        if (w_start_rise) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_recentre = (w_next == ST_IDLE) ||
                      (w_next == ST_SERVE) ||
                      (w_next == ST_GAME_OVER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ball_step <= 1'b0;
      r_recentre  <= 1'b1;
      r_serve_dir <= DIR_LEFT;
      r_score_l   <= 4'd0;
      r_score_r   <= 4'd0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_start_d   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ball_step <= w_step;
      r_recentre  <= w_recentre;
      r_serve_dir <= w_serve_dir;
      r_score_l   <= w_score_l;
      r_score_r   <= w_score_r;
      r_game_over <= (w_next == ST_GAME_OVER);
      r_winner    <= w_winner;
      r_start_d   <= start;
    end
  end

`ifdef PONG_SPEEDUP_EN
  localparam logic [3:0] LP_HPL = HITS_PER_LEVEL[3:0];

  logic [3:0] r_hits;
  logic [2:0] r_speed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hits  <= 4'd0;
      r_speed <= 3'd0;
    end else if (w_enter_serve) begin
      r_hits  <= 4'd0;
      r_speed <= 3'd0;
    end else if ((r_state == ST_PLAY) && paddle_hit) begin
      if (inc4(r_hits) == LP_HPL) begin
        r_hits <= 4'd0;
        if (r_speed != 3'd7) begin
          r_speed <= r_speed + 3'd1;
        end
      end else begin
        r_hits <= inc4(r_hits);
      end
    end
  end

  assign speed_lvl = r_speed;
`else
  logic w_unused;
  assign w_unused  = paddle_hit ^ (HITS_PER_LEVEL == 0);
  assign speed_lvl = 3'd0;
`endif

  assign ball_step     = r_ball_step;
  assign ball_recentre = r_recentre;
  assign serve_dir     = r_serve_dir;
  assign score_l       = r_score_l;
  assign score_r       = r_score_r;
  assign state_o       = r_state;
  assign game_over     = r_game_over;
  assign winner        = r_winner;

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Round/match sequencer for the pong datapath. Sits between the frame timing source, the ball mover and the paddle/score display.
- Gates ball motion to one step per video frame. Holds the ball centred during serve and after-goal delays.
- Keeps both players' scores and declares a winner at a target score.
- Its outputs directly drive the ball block's step enable, recentre and initial-direction inputs.

Parameters:
- WIN_SCORE, 7, points needed to win; range 1..15.
- SERVE_FRAMES, 60, frames the ball sits centred before a serve; range 1..255.
- GOAL_FRAMES, 30, frames the goal position is frozen on screen before recentre; range 1..255.
- HITS_PER_LEVEL, 4, paddle hits per speed-level increment (SPEEDUP_EN only); range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  single-cycle pulse, once per frame (end of vsync)
- start  in  1  level; debounced start/serve button
- pause  in  1  level; freezes play while high
- goal_l  in  1  single-cycle pulse; ball has left the field at the left edge
- goal_r  in  1  single-cycle pulse; ball has left the field at the right edge
- paddle_hit  in  1  single-cycle pulse; ball bounced off either paddle
- ball_step  out  1  single-cycle pulse; ball advances one move
- ball_recentre  out  1  level; ball forced to centre while high
- serve_dir  out  1  initial x direction; 1 = toward left, 0 = toward right
- score_l  out  4  left player score
- score_r  out  4  right player score
- state_o  out  3  current FSM state, for debug LEDs
- game_over  out  1  high in GAME_OVER
- winner  out  1  0 = left won, 1 = right won; valid while game_over
- speed_lvl  out  3  ball speed level; tied to 0 without SPEEDUP_EN

Behaviour:
- Reset values: state IDLE; scores 0; ball_step 0; ball_recentre 1; serve_dir 1; game_over 0; winner 0; speed_lvl 0; frame counter 0.
- All outputs are registered.

FSM states and transitions:
- IDLE (0): ball_recentre=1. On start=1, clear both scores, set serve_dir=1, load the counter with SERVE_FRAMES, go to SERVE.
- SERVE (1): ball_recentre=1. On each frame_tick with pause=0, decrement the counter. On the tick that takes the counter from 1 to 0, go to PLAY. pause=1 stalls the countdown.
- PLAY (2): ball_recentre=0. On frame_tick with pause=0, assert ball_step for exactly one cycle, on the cycle after the tick (1-cycle latency). When pause=1, no steps are issued.
- Goal handling in PLAY:
  - goal_l: score_r+1 and serve_dir=1 (next serve goes toward the player who conceded).
  - goal_r: score_l+1 and serve_dir=0.
  - goal_l and goal_r in the same cycle: goal_l takes priority; goal_r is dropped.
  - After any goal: load the counter with GOAL_FRAMES and go to GOAL_HOLD. No ball_step is issued in the goal cycle.
- Inputs ignored outside PLAY: goal_l, goal_r and paddle_hit.
- GOAL_HOLD (3): ball_recentre=0 (ball stays frozen, no steps). Count down on frame_tick; pause does not stall this countdown. At 0:
  - if either score equals WIN_SCORE: go to GAME_OVER, with winner=(score_r==WIN_SCORE);
  - otherwise: load SERVE_FRAMES, go to SERVE.
- GAME_OVER (4): game_over=1, ball_recentre=1. Scores are held. start must be seen low and then high (rising edge, detected internally) to go to IDLE. Start held from the previous game does not restart.
- Score arithmetic: 4-bit unsigned. Scores never exceed WIN_SCORE because the increment happens only in PLAY.
- Simultaneous frame_tick and goal in PLAY: the goal wins and no ball_step is issued.
- reset asserted mid-operation: everything returns to reset values immediately (asynchronous).
- Encodings 5-7 are unreachable and recover to IDLE on the next clock.

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- Defined:
  - A 4-bit hit counter increments on paddle_hit in PLAY.
  - When the counter reaches HITS_PER_LEVEL it clears, and speed_lvl increments, saturating at 7.
  - The hit counter and speed_lvl clear on every entry to SERVE.
  - speed_lvl is meant to scale the ball's dx/dy (3 + speed_lvl).
- Undefined: no hit counter; speed_lvl is constant 0; paddle_hit is unused.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding constants: ST_IDLE=0, ST_SERVE=1, ST_PLAY=2, ST_GOAL_HOLD=3, ST_GAME_OVER=4;
  - DIR_LEFT=1 and DIR_RIGHT=0;
  - field constants 640 and 480, shared with the ball and paddle blocks.
- One sub-module, frame_delay_ctr: an 8-bit loadable down-counter with enable=frame_tick, a load input and a zero flag. It is reused for the SERVE and GOAL_HOLD delays.

Test Plan:
- Reset, then start=1 → SERVE, with ball_recentre=1 for 60 frame_ticks. First ball_step comes exactly 1 cycle after the 61st tick; serve_dir=1.
- In PLAY, pulse goal_l → score_r=1, serve_dir=1, no step that frame. After 30 ticks in GOAL_HOLD: SERVE, with ball_recentre=1.
- goal_l and goal_r in the same cycle → only score_r increments; score_l is unchanged.
- Drive goal_r seven times → score_l=7. After GOAL_HOLD: game_over=1, winner=0. Holding start=1 stays in GAME_OVER; releasing then pressing start → IDLE, then SERVE with scores 0.
- In PLAY, pause=1 for 10 frame_ticks → zero ball_step pulses. Pause in SERVE extends the countdown by 10 ticks.
- With PONG_SPEEDUP_EN, 9 paddle_hit pulses → speed_lvl=2. After a goal and re-serve → speed_lvl=0. Without the macro, speed_lvl=0 throughout.
